uart_recv: RTL and testbench
============================

// Module: uart_recv
// PURPOSE
//   8N1 UART receiver; the receive-side counterpart of the GPSDO UART transmitter.
//   Recovers bytes from the serial line (e.g. GPS NMEA/UBX stream) and presents each byte
//   with a one-cycle strobe, plus a framing-error strobe. Sits between the RXD pin and the parser.
// PARAMETERS
//   CLK_FREQ   50000000  system clock frequency, Hz
//   UART_BPS   9600      baud rate; BPS_CNT = CLK_FREQ/UART_BPS, HALF_CNT = BPS_CNT/2
// PORTS
//   CLK_SYS     in   1  system clock
//   CLK_RST     in   1  reset, synchronous, active-high
//   uart_rxd    in   1  async serial input, idle high
//   uart_done   out  1  one-cycle strobe: uart_data holds a new valid byte
//   uart_data   out  8  last good byte, LSB first on line; held until next good frame
//   frame_err   out  1  one-cycle strobe: stop bit sampled low, byte discarded
//   rx_busy     out  1  high while state != IDLE
// BEHAVIOUR
//   Reset (CLK_RST=1 at posedge): state=IDLE, clk_cnt=0, bit_cnt=0, shift=0, sync regs=1,
//     uart_done=0, frame_err=0, uart_data=0, rx_busy=0. Reset mid-frame aborts frame, no strobe.
//   Sync: uart_rxd -> rx_d0 -> rx_d1 -> rx_d2; start edge = rx_d2 & ~rx_d1; sampled bit = rx_d1.
//   clk_cnt 16 bit: increments every cycle outside IDLE; cleared on every state change and on wrap.
//   FSM:
//     IDLE : on start edge -> START, clk_cnt=0.
//     START: at clk_cnt==HALF_CNT-1: rx_d1==0 -> DATA (clk_cnt=0, bit_cnt=0);
//            rx_d1==1 -> IDLE (glitch rejected, no strobe).
//     DATA : at clk_cnt==BPS_CNT-1 (mid-bit): shift <= {rx_d1, shift[7:1]}, clk_cnt=0;
//            bit_cnt==7 -> STOP, else bit_cnt+1.
//     STOP : at clk_cnt==BPS_CNT-1: rx_d1==1 -> uart_data<=shift, uart_done=1;
//            rx_d1==0 -> frame_err=1, uart_data unchanged; both -> IDLE.
//   Strobes registered: high exactly the cycle after the stop-sample edge, then 0.
//     Never both high together.
//   Return to IDLE at mid-stop: start edge of a back-to-back frame is accepted on the next cycle.
//   Start edge while not IDLE: ignored.
//   Line held low (break): frame_err once; no new frame until line returns high and falls again.
//   Latency: uart_rxd falling edge -> uart_done = 3 + HALF_CNT + 9*BPS_CNT + 1 cycles (+/-1).
// TESTING (sim params CLK_FREQ=1000000, UART_BPS=100000 -> BPS_CNT=10, HALF_CNT=5)
//   Reset, rxd=1 idle 100 cycles -> uart_done=0, frame_err=0, rx_busy=0, uart_data=8'h00.
//   Send 0x55 then 0xA3, 10 cycles/bit, no idle gap -> two uart_done pulses,
//     uart_data=8'h55 then 8'hA3, each pulse 1 cycle wide.
//   Low glitch of 3 cycles on idle line -> rx_busy high ~6 cycles, back to IDLE, no strobes.
//   Frame 0x3C with stop bit driven 0 -> frame_err 1 cycle, uart_done=0,
//     uart_data keeps previous value.
//   CLK_RST=1 for 1 cycle during bit 4 of 0xF0 -> no strobe, rx_busy=0;
//     next full frame 0x81 -> uart_data=8'h81.
//   Baud skew: send 0x96 with bit period 9 and 11 cycles -> uart_data=8'h96, no frame_err.

Source files
------------

// File: rtl/uart_recv.sv
// 8N1 UART receiver: falling start edge -> uart_done about 3+HALF_CNT+9*BPS_CNT+1 cycles later.
// No backpressure: uart_done/frame_err are single-cycle strobes that the consumer must take immediately.
module uart_recv #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 9600
) (
  input  logic       CLK_SYS,
  input  logic       CLK_RST,
  input  logic       uart_rxd,
  output logic       uart_done,
  output logic [7:0] uart_data,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int          BPS_CNT   = CLK_FREQ / UART_BPS;
  localparam int          HALF_CNT  = BPS_CNT / 2;
  localparam logic [15:0] BPS_LAST  = 16'(BPS_CNT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_CNT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]  state_q,   state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q,   shift_d;
  logic [7:0]  data_q,    data_d;
  logic [2:0]  sync_q,    sync_d;
  logic        done_q,    done_d;
  logic        err_q,     err_d;

  logic rx_bit;
  logic start_edge;

  // sync_q[0..2] are rx_d0..rx_d2; rx_d1 is the first metastability-safe sample
  assign rx_bit     = sync_q[1];
  assign start_edge = sync_q[2] & ~sync_q[1];

  always_comb begin
    sync_d    = {sync_q[1:0], uart_rxd};
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + 16'd1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        clk_cnt_d = 16'd0;
        if (start_edge) state_d = START;
      end
      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = 16'd0;
          bit_cnt_d = 3'd0;
          state_d   = rx_bit ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt_q == BPS_LAST) begin
          clk_cnt_d = 16'd0;
          shift_d   = {rx_bit, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = STOP;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      default: begin
        // Leave at mid-stop so a back-to-back start edge is not missed
        if (clk_cnt_q == BPS_LAST) begin
          clk_cnt_d = 16'd0;
          state_d   = IDLE;
          if (rx_bit) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK_SYS) begin
    if (CLK_RST) begin
      state_q   <= IDLE;
      clk_cnt_q <= 16'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      data_q    <= 8'd0;
      sync_q    <= 3'b111;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      sync_q    <= sync_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign uart_done = done_q;
  assign frame_err = err_q;
  assign uart_data = data_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv at BPS_CNT=10, HALF_CNT=5; inputs driven on the falling clock edge.
module tb_uart_recv;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic       uart_done;
  logic [7:0] uart_data;
  logic       frame_err;
  logic       rx_busy;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int busy_cycles = 0;
  int lat = 0;
  int t_fall = 0;
  bit wide_pulse = 0;
  bit both_high = 0;
  logic prev_done = 1'b0;
  logic prev_err = 1'b0;
  logic [7:0] got_q[$];

  uart_recv #(.CLK_FREQ(1000000), .UART_BPS(100000)) dut (
    .CLK_SYS  (clk),
    .CLK_RST  (rst),
    .uart_rxd (rxd),
    .uart_done(uart_done),
    .uart_data(uart_data),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_done <= uart_done;
    prev_err  <= frame_err;
    if (uart_done) begin
      done_cnt <= done_cnt + 1;
      got_q.push_back(uart_data);
      lat <= cyc - t_fall;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
    if (rx_busy) busy_cycles <= busy_cycles + 1;
    if ((uart_done && prev_done) || (frame_err && prev_err)) wide_pulse <= 1'b1;
    if (uart_done && frame_err) both_high <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Slots: start, d0..d7, stop; even slots last p_even cycles, odd slots p_odd
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int p_even, input int p_odd);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      if (i == 0) t_fall = cyc;
      repeat ((i % 2 == 0) ? p_even : p_odd) @(negedge clk);
    end
  endtask

  int d0, e0, sz;

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", rx_busy, 1'b0);
    check("rst_data", uart_data, 8'h00);
    rst = 1'b0;

    idle(100);
    check("idle_done", done_cnt, 0);
    check("idle_err", err_cnt, 0);
    check("idle_busy", rx_busy, 1'b0);
    check("idle_data", uart_data, 8'h00);

    // Two back-to-back frames, no idle gap
    send_frame(8'h55, 1'b1, 10, 10);
    send_frame(8'hA3, 1'b1, 10, 10);
    idle(20);
    check("b2b_count", done_cnt, 2);
    sz = got_q.size();
    check("b2b_qsize", sz, 2);
    if (sz >= 2) begin
      check("b2b_first", got_q[0], 8'h55);
      check("b2b_second", got_q[1], 8'hA3);
    end
    check("b2b_data", uart_data, 8'hA3);
    check("b2b_err", err_cnt, 0);
    check("latency_ok", (lat >= 98 && lat <= 100), 1'b1);

    // 3-cycle low glitch on idle line
    d0 = done_cnt; e0 = err_cnt;
    busy_cycles = 0;
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    idle(30);
    check("glitch_busy_seen", (busy_cycles >= 4 && busy_cycles <= 7), 1'b1);
    check("glitch_idle", rx_busy, 1'b0);
    check("glitch_done", done_cnt - d0, 0);
    check("glitch_err", err_cnt - e0, 0);

    // Stop bit driven low
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h3C, 1'b0, 10, 10);
    idle(20);
    check("ferr_err", err_cnt - e0, 1);
    check("ferr_done", done_cnt - d0, 0);
    check("ferr_data", uart_data, 8'hA3);

    // Reset pulse inside bit 4 of 0xF0 (line is high there)
    d0 = done_cnt; e0 = err_cnt;
    fork
      send_frame(8'hF0, 1'b1, 10, 10);
      begin
        repeat (55) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_busy", rx_busy, 1'b0);
      end
    join
    idle(20);
    check("rstmid_done", done_cnt - d0, 0);
    check("rstmid_err", err_cnt - e0, 0);
    check("rstmid_data", uart_data, 8'h00);
    d0 = done_cnt;
    send_frame(8'h81, 1'b1, 10, 10);
    idle(20);
    check("after_rst_done", done_cnt - d0, 1);
    check("after_rst_data", uart_data, 8'h81);

    // Bit-period jitter: alternating 9/11 and 11/9 cycle slots
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h96, 1'b1, 9, 11);
    idle(20);
    check("skew_a_data", uart_data, 8'h96);
    uart_data_clear_probe();
    send_frame(8'h96, 1'b1, 11, 9);
    idle(20);
    check("skew_b_data", uart_data, 8'h96);
    check("skew_done", done_cnt - d0, 3);
    check("skew_err", err_cnt - e0, 0);

    // Break: line held low well past one frame
    d0 = done_cnt; e0 = err_cnt;
    rxd = 1'b0;
    repeat (150) @(negedge clk);
    check("break_err", err_cnt - e0, 1);
    check("break_done", done_cnt - d0, 0);
    check("break_idle", rx_busy, 1'b0);
    idle(30);
    check("break_no_more", err_cnt - e0, 1);
    send_frame(8'h5A, 1'b1, 10, 10);
    idle(20);
    check("break_recover", uart_data, 8'h5A);

    check("strobe_width", wide_pulse, 1'b0);
    check("strobe_overlap", both_high, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Separates the two skew frames with a distinct byte so the second 0x96 is a fresh capture
  task automatic uart_data_clear_probe();
    send_frame(8'h00, 1'b1, 10, 10);
    idle(20);
    check("skew_sep_data", uart_data, 8'h00);
  endtask

endmodule
